// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback stage: 16x64 regfile, bypassed reads, pending-writer scoreboard
// Optional R0_ZERO_EN hardwires register 0 to zero.
module writeback_regfile #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 64,
    parameter int PEND_MAX = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W+4:0]           write,
    input  logic                        wb_stall,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_addr,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_addr,
    output logic [DATA_W-1:0]           rs1_data,
    output logic [DATA_W-1:0]           rs2_data,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    input  logic                        issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
    output logic                        issue_ok,
    output logic [31:0]                 retire_count,
    output logic [$clog2(NUM_REGS)-1:0] last_wb_reg
);
    localparam int IDXW = $clog2(NUM_REGS);
    localparam int PW   = $clog2(PEND_MAX + 1);

    logic [DATA_W-1:0]   regs    [NUM_REGS];
    logic [PW-1:0]       pending [NUM_REGS];

    logic                wr_en;
    logic [IDXW-1:0]     wr_rd;
    logic [DATA_W-1:0]   wr_val;
    logic                commit;
    logic                issue_acc;
    logic                reg_we;
    logic                dec1;
    logic                dec2;
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;

    assign wr_en  = write[DATA_W+4];
    assign wr_rd  = write[DATA_W+3:DATA_W];
    assign wr_val = write[DATA_W-1:0];
    assign commit = wr_en & ~wb_stall & ~reset;

    // issue_ok looks only at the stored count; a same-cycle retire does not free a slot
    assign issue_ok  = (pending[issue_rd] != PW'(PEND_MAX));
    assign issue_acc = issue_valid & issue_ok & ~reset;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        reg_we  = commit;
        if (issue_acc)
            inc_vec = NUM_REGS'(1) << issue_rd;
        if (commit && pending[wr_rd] != '0)
            dec_vec = NUM_REGS'(1) << wr_rd;
`ifdef R0_ZERO_EN
        inc_vec[0] = 1'b0;
        if (wr_rd == '0)
            reg_we = 1'b0;
`endif
    end

    assign dec1 = commit && (rs1_addr == wr_rd) && (pending[rs1_addr] != '0);
    assign dec2 = commit && (rs2_addr == wr_rd) && (pending[rs2_addr] != '0);

    // A retiring producer is bypassed, so it no longer counts towards busy
    always_comb begin
        rs1_data = (commit && rs1_addr == wr_rd) ? wr_val : regs[rs1_addr];
        rs2_data = (commit && rs2_addr == wr_rd) ? wr_val : regs[rs2_addr];
        rs1_busy = (pending[rs1_addr] - PW'(dec1)) != '0;
        rs2_busy = (pending[rs2_addr] - PW'(dec2)) != '0;
`ifdef R0_ZERO_EN
        if (rs1_addr == '0) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
        end
        if (rs2_addr == '0) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]    <= '0;
                pending[i] <= '0;
            end
            retire_count <= '0;
            last_wb_reg  <= '0;
        end else begin
            if (reg_we)
                regs[wr_rd] <= wr_val;
            if (commit) begin
                retire_count <= retire_count + 32'd1;
                last_wb_reg  <= wr_rd;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    pending[i] <= pending[i] + PW'(1);
                else if (dec_vec[i] && !inc_vec[i])
                    pending[i] <= pending[i] - PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - scoreboard bench for writeback_regfile
module tb_writeback_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic [68:0] write;
    logic        wb_stall;
    logic [3:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic        issue_valid;
    logic [3:0]  issue_rd;
    logic        issue_ok;
    logic [31:0] retire_count;
    logic [3:0]  last_wb_reg;

    writeback_regfile dut (
        .clk(clk), .reset(reset), .write(write), .wb_stall(wb_stall),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ok(issue_ok),
        .retire_count(retire_count), .last_wb_reg(last_wb_reg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    localparam int S_D1 = 0, S_D2 = 1, S_B1 = 2, S_B2 = 3, S_OK = 4, S_RC = 5, S_LAST = 6;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] ref_regs [16];
    logic [31:0] ref_retire;
    logic [3:0]  ref_last;
    bit          r0_zero;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            S_D1:    return rs1_data;
            S_D2:    return rs2_data;
            S_B1:    return 64'(rs1_busy);
            S_B2:    return 64'(rs2_busy);
            S_OK:    return 64'(issue_ok);
            S_RC:    return 64'(retire_count);
            default: return 64'(last_wb_reg);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // Reference state advances with the same edge that updates the DUT
    task automatic step();
        if (reset) begin
            for (int i = 0; i < 16; i++) ref_regs[i] = '0;
            ref_retire = '0;
            ref_last   = '0;
        end else if (write[68] && !wb_stall) begin
            if (!(r0_zero && write[67:64] == 4'd0))
                ref_regs[write[67:64]] = write[63:0];
            ref_retire++;
            ref_last = write[67:64];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write       = '0;
        wb_stall    = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic expect_counters(input string tag);
        expect_val({tag, "_rc"}, S_RC, 64'(ref_retire));
        expect_val({tag, "_last"}, S_LAST, 64'(ref_last));
    endtask

    initial begin
`ifdef R0_ZERO_EN
        r0_zero = 1'b1;
`else
        r0_zero = 1'b0;
`endif
        for (int i = 0; i < 16; i++) ref_regs[i] = '0;
        ref_retire = '0;
        ref_last   = '0;
        reset = 1'b1;
        idle();
        rs1_addr = 4'd5;
        rs2_addr = 4'd0;
        issue_rd = 4'd0;
        step();
        step();
        reset = 1'b0;

        expect_val("rst_d1", S_D1, 64'd0);
        expect_val("rst_b1", S_B1, 64'd0);
        expect_val("rst_ok", S_OK, 64'd1);
        expect_val("rst_rc", S_RC, 64'd0);
        expect_val("rst_last", S_LAST, 64'd0);
        drain();

        write = {1'b1, 4'd5, 64'd9};
        step();
        idle();
        expect_val("wr5_d1", S_D1, 64'd9);
        expect_val("wr5_rc", S_RC, 64'd1);
        expect_val("wr5_last", S_LAST, 64'd5);
        drain();

        rs1_addr = 4'd3;
        write = {1'b1, 4'd3, 64'hDEAD};
        expect_val("byp_d1", S_D1, 64'hDEAD);
        drain();
        step();
        idle();
        expect_val("byp_after", S_D1, 64'hDEAD);
        expect_counters("byp");
        drain();

        write = {1'b1, 4'd3, 64'hBEEF};
        wb_stall = 1'b1;
        expect_val("stall_d1", S_D1, 64'hDEAD);
        drain();
        step();
        idle();
        expect_val("stall_after", S_D1, 64'hDEAD);
        expect_counters("stall");
        drain();

        rs1_addr = 4'd7;
        issue_rd = 4'd7;
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1;
            expect_val("sat_ok_pre", S_OK, 64'd1);
            drain();
            step();
        end
        expect_val("sat_ok0", S_OK, 64'd0);
        expect_val("sat_busy", S_B1, 64'd1);
        drain();
        step();
        issue_valid = 1'b0;
        expect_val("sat_4th_ignored", S_OK, 64'd0);
        drain();
        for (int k = 0; k < 3; k++) begin
            write = {1'b1, 4'd7, 64'(k + 100)};
            expect_val("sat_busy_in", S_B1, (k == 2) ? 64'd0 : 64'd1);
            if (k == 0) expect_val("sat_ok_same_cycle", S_OK, 64'd0);
            drain();
            step();
            idle();
            expect_val("sat_ok_after", S_OK, 64'd1);
            expect_val("sat_busy_after", S_B1, (k == 2) ? 64'd0 : 64'd1);
            drain();
        end

        rs2_addr = 4'd2;
        issue_rd = 4'd2;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b1;
        write = {1'b1, 4'd2, 64'h22};
        expect_val("ic_busy_same", S_B2, 64'd0);
        expect_val("ic_d2", S_D2, 64'h22);
        drain();
        step();
        idle();
        expect_val("ic_busy_next", S_B2, 64'd1);
        drain();
        write = {1'b1, 4'd2, 64'h23};
        step();
        idle();
        expect_val("ic_busy_clear", S_B2, 64'd0);
        drain();

        rs1_addr = 4'd4;
        write = {1'b0, 4'd4, 64'd77};
        step();
        idle();
        expect_val("nowr_d1", S_D1, 64'd0);
        expect_counters("nowr");
        drain();

`ifdef R0_ZERO_EN
        rs1_addr = 4'd0;
        write = {1'b1, 4'd0, 64'd55};
        expect_val("r0_same", S_D1, 64'd0);
        drain();
        step();
        idle();
        expect_val("r0_next", S_D1, 64'd0);
        expect_counters("r0");
        drain();
        issue_rd = 4'd0;
        issue_valid = 1'b1;
        step();
        idle();
        expect_val("r0_busy", S_B1, 64'd0);
        drain();
`else
        rs1_addr = 4'd0;
        write = {1'b1, 4'd0, 64'd55};
        step();
        idle();
        expect_val("r0_plain", S_D1, 64'd55);
        expect_counters("r0");
        drain();
        issue_rd = 4'd0;
        issue_valid = 1'b1;
        step();
        idle();
        expect_val("r0_busy", S_B1, 64'd1);
        drain();
        write = {1'b1, 4'd0, 64'd56};
        step();
        idle();
`endif

        for (int k = 0; k < 40; k++) begin
            logic [3:0]  rd;
            logic [63:0] val;
            logic        en, st;
            rd  = 4'($urandom_range(0, 15));
            val = {$urandom, $urandom};
            en  = 1'($urandom_range(0, 3) != 0);
            st  = 1'($urandom_range(0, 3) == 0);
            rs1_addr = 4'($urandom_range(0, 15));
            rs2_addr = (k % 3 == 0) ? rd : 4'($urandom_range(0, 15));
            write = {en, rd, val};
            wb_stall = st;
            if (r0_zero && rs1_addr == 4'd0)
                expect_val("rnd_d1", S_D1, 64'd0);
            else
                expect_val("rnd_d1", S_D1, (en && !st && rs1_addr == rd) ? val : ref_regs[rs1_addr]);
            if (r0_zero && rs2_addr == 4'd0)
                expect_val("rnd_d2", S_D2, 64'd0);
            else
                expect_val("rnd_d2", S_D2, (en && !st && rs2_addr == rd) ? val : ref_regs[rs2_addr]);
            expect_val("rnd_b1", S_B1, 64'd0);
            drain();
            step();
            idle();
            expect_counters("rnd");
            drain();
        end

        rs1_addr = 4'd9;
        rs2_addr = 4'd5;
        issue_rd = 4'd9;
        issue_valid = 1'b1;
        step();
        step();
        expect_val("mid_busy_pre", S_B1, 64'd1);
        drain();
        reset = 1'b1;
        write = {1'b1, 4'd5, 64'd123};
        step();
        reset = 1'b0;
        idle();
        expect_val("mid_busy", S_B1, 64'd0);
        expect_val("mid_d1", S_D1, 64'd0);
        expect_val("mid_d2", S_D2, 64'd0);
        expect_val("mid_ok", S_OK, 64'd1);
        expect_val("mid_rc", S_RC, 64'd0);
        expect_val("mid_last", S_LAST, 64'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback stage directly downstream of memory access. Consumes the 69-bit MA output bus: value [63:0], destination register [67:64], isWrite [68].
- Commits results into a 16 x 64-bit register file.
- Serves two combinational read ports to operand fetch, with same-cycle write bypass.
- Keeps a per-register pending-writer scoreboard so operand fetch can detect RAW hazards against in-flight instructions.

Parameters:
- NUM_REGS, 16, register count; index width is 4 bits, matching the MA bus field.
- DATA_W, 64, register and data width.
- PEND_MAX, 3, maximum in-flight writers tracked per register (OF→EX→MA→WB depth).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- write  in  69  MA output bus: [63:0] value, [67:64] dest reg, [68] isWrite
- wb_stall  in  1  holds writeback; no commit and no pending clear this cycle
- rs1_addr  in  4  read port 1 index
- rs2_addr  in  4  read port 2 index
- rs1_data  out  64  read port 1 data (bypassed)
- rs2_data  out  64  read port 2 data (bypassed)
- rs1_busy  out  1  pending count of rs1_addr, after this cycle's commit, is nonzero
- rs2_busy  out  1  same for rs2_addr
- issue_valid  in  1  OF issues an instruction that will write issue_rd
- issue_rd  in  4  destination of the issuing instruction
- issue_ok  out  1  low when pending[issue_rd] == PEND_MAX; issue is refused
- retire_count  out  32  number of committed register writes
- last_wb_reg  out  4  destination of the most recent commit

Behaviour:
- Reset, synchronous and active-high:
  - all registers are 0;
  - all pending counters are 0;
  - retire_count is 0;
  - last_wb_reg is 0.
  - Combinational outputs after reset: rs*_data = 0 (unless a bypass applies), rs*_busy = 0, issue_ok = 1.
  - A commit or issue presented in the reset cycle is discarded.
- Commit condition: commit = write[68] & ~wb_stall & ~reset. On the rising edge:
  - regs[write[67:64]] <= write[63:0];
  - retire_count increments, wrapping from 0xFFFFFFFF to 0;
  - last_wb_reg <= write[67:64].
- Read ports are combinational, zero latency.
  - If commit is asserted and rsN_addr == write[67:64], rsN_data = write[63:0] (write-through bypass).
  - Otherwise rsN_data = regs[rsN_addr].
- Pending scoreboard: one 2-bit counter per register.
  - Accepted issue: issue_valid & issue_ok. Increments pending[issue_rd].
  - Commit decrements pending[write[67:64]] if it is nonzero. A commit to a register with count 0 still writes the register file; the counter stays at 0 (no underflow).
  - Accepted issue and commit to the same register in one cycle: count unchanged.
  - issue_ok depends only on the current count; a commit in the same cycle does not relax it.
  - rsN_busy = (pending[rsN_addr] − (commit & rsN_addr == write[67:64] & pending != 0)) != 0. A producer retiring this cycle therefore does not report busy, because its value is bypassed.
  - issue_valid while issue_ok = 0: no counter change.
- wb_stall blocks commit, counter decrement and retire_count update, and disables the bypass. Issue is still accepted during a stall.
- Width rules: the value is written at full 64 bits, with no sign or zero extension.

Optional Feature:
- Macro: R0_ZERO_EN.
- When defined, register 0 is hardwired to zero:
  - commits to reg 0 do not change the register file;
  - rs*_data for address 0 is always 0, including via bypass;
  - pending[0] never increments;
  - rs*_busy for address 0 is always 0;
  - commits to reg 0 still update retire_count and last_wb_reg.
- When undefined, reg 0 is an ordinary register.

Test Plan:
- Reset, then write = {1, 4'd5, 64'd9} for one cycle; next cycle rs1_addr=5 → rs1_data = 9, retire_count = 1, last_wb_reg = 5.
- Bypass: commit {1, 4'd3, 64'hDEAD} with rs1_addr=3 in the same cycle → rs1_data = 0xDEAD combinationally. With wb_stall=1 instead → rs1_data = old value and the register is unchanged afterwards.
- Scoreboard saturation: three accepted issues to rd=7 → pending = 3, issue_ok = 0 with issue_rd=7. A fourth issue is ignored. One commit to 7 → issue_ok = 1 the next cycle. rs1_busy(7) stays 1 until the third commit.
- Same-cycle issue and commit to rd=2 with pending = 1 → pending stays 1, rs2_busy(2) = 0 that cycle (the retiring writer is bypassed), rs2_busy(2) = 1 the next cycle.
- isWrite = 0 bus {0, 4'd4, 64'd77} → reg 4 unchanged, retire_count unchanged. Reset asserted mid-stream with pending counts nonzero → all counts, registers and counters return to 0 the next cycle.
- With R0_ZERO_EN: commit {1, 4'd0, 64'd55} → rs1_data(0) = 0 in the same and the next cycle, retire_count increments, and issue to rd=0 leaves rs1_busy(0) = 0.
